dm_access_unit: RTL

- Data-memory stage directly downstream of the address register (AR).
- Takes the 16-bit data memory address AR drives on DMADDR, plus write data and read/write strobes from the control unit.
- Performs a multi-cycle access to a local word-addressed RAM and returns read data for the bus/DR path with a BUSY/DONE handshake.
- The control unit stalls on BUSY instead of assuming single-cycle memory.

---
 rtl/dm_pkg.sv | 24 ++
 rtl/dm_access_unit_if.sv | 27 ++
 rtl/dm_ram.sv | 35 +++
 rtl/dm_access_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and default widths for the data-memory access path.
package dm_pkg;

  localparam int DM_DATA_W     = 16;
  localparam int DM_ADDR_W     = 8;
  localparam int DM_BUS_ADDR_W = 16;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_ACCESS,
    DM_FIN
  } dm_state_e;

  typedef enum logic {
    DM_OP_RD = 1'b0,
    DM_OP_WR = 1'b1
  } dm_op_e;

  // Address is usable only when every bit above the implemented RAM range is zero.
  function automatic logic dm_addr_ok(input logic [DM_BUS_ADDR_W-1:0] addr, input int addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Request/response bundle between the control unit (master) and the data-memory stage (slave).
interface dm_access_unit_if
  import dm_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W
);

  logic [DM_BUS_ADDR_W-1:0] DMADDR;
  logic [DATA_W-1:0]        DMWDATA;
  logic                     RD_EN;
  logic                     WR_EN;
  logic [DATA_W-1:0]        DMRDATA;
  logic                     BUSY;
  logic                     DONE;
  logic                     ERR;

  modport master (
    output DMADDR, DMWDATA, RD_EN, WR_EN,
    input  DMRDATA, BUSY, DONE, ERR
  );

  modport slave (
    input  DMADDR, DMWDATA, RD_EN, WR_EN,
    output DMRDATA, BUSY, DONE, ERR
  );

endinterface

// File: rtl/dm_ram.sv
// Single-port word RAM with a registered read port; the read register holds
// its value until the next read enable and is the only resettable state here.
module dm_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_access_unit.sv
// Multi-cycle data-memory access stage: captures a request from AR/bus, waits
// MEM_LATENCY cycles, commits to the local RAM and reports BUSY/DONE/ERR.
//
// state     | meaning
// DM_IDLE   | waiting for RD_EN/WR_EN; only state that accepts a request
// DM_ACCESS | request captured, latency counter running down to commit
// DM_FIN    | DONE pulse (with ERR if the request was rejected)
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int DATA_W      = DM_DATA_W,
  parameter int ADDR_W      = DM_ADDR_W,
  parameter int MEM_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  dm_access_unit_if.slave  bus
);

  localparam logic [3:0] LAT_CNT = 4'(MEM_LATENCY - 1);

  dm_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  dm_op_e            op_q, op_d;
  logic              err_q, err_d;
  logic              ram_we, ram_re;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= DM_OP_RD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      DM_IDLE: begin
        if (bus.RD_EN || bus.WR_EN) begin
          if ((bus.RD_EN && bus.WR_EN) || !dm_addr_ok(bus.DMADDR, ADDR_W)) begin
            err_d   = 1'b1;
            state_d = DM_FIN;
          end else begin
            addr_d  = bus.DMADDR[ADDR_W-1:0];
            wdata_d = bus.DMWDATA;
            op_d    = bus.WR_EN ? DM_OP_WR : DM_OP_RD;
            cnt_d   = LAT_CNT;
            err_d   = 1'b0;
            state_d = DM_ACCESS;
          end
        end
      end
      DM_ACCESS: begin
        if (cnt_q == 4'd0) begin
          ram_we  = (op_q == DM_OP_WR);
          ram_re  = (op_q == DM_OP_RD);
          state_d = DM_FIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DM_FIN: begin
        err_d   = 1'b0;
        state_d = DM_IDLE;
      end
      default: state_d = DM_IDLE;
    endcase
  end

  // A commit edge that coincides with reset must not reach the array.
  dm_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we && !rst),
    .re_i    (ram_re && !rst),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.DMRDATA)
  );

  assign bus.BUSY = (state_q == DM_ACCESS);
  assign bus.DONE = (state_q == DM_FIN);
  assign bus.ERR  = (state_q == DM_FIN) && err_q;

endmodule
